// File: rtl/dsm_cic_decim.sv
// Third-order CIC decimator for a 1-bit delta-sigma bitstream.
// Decimates by R = 2**DECIM_LOG2 and emits a full-precision OUT_W-bit sample
// with a one-cycle dout_valid strobe.
// Optional build macro: CIC_BIPOLAR_EN. When it is defined, MSB maps to
// -1/+1 and dout is signed. When it is undefined, MSB maps to 0/+1 and
// dout is unsigned.
module dsm_cic_decim #(
  parameter int DECIM_LOG2 = 6   // legal range 2..10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MSB,
  output logic [3*DECIM_LOG2+1:0]   dout,
  output logic                      dout_valid
);

  // Integrator/comb/output width. The unsigned gain R^3 needs 3*DECIM_LOG2+1
  // bits. The extra bit keeps the bipolar result representable.
  localparam int OUT_W = 3*DECIM_LOG2 + 2;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;   // R-1

  logic [OUT_W-1:0]      x;
  logic [OUT_W-1:0]      i1, i2, i3;
  logic [OUT_W-1:0]      d1, d2, d3;
  logic [OUT_W-1:0]      c1, c2, c3;
  logic [DECIM_LOG2-1:0] cnt;
  logic                  strobe;

  // Map the input bit to a sample and evaluate the combs from pre-edge state.
  // NOTE: every always_comb output gets a default first, so that no path can infer a latch.
  always_comb begin
    x      = '0;
`ifdef CIC_BIPOLAR_EN
    x      = MSB ? {{(OUT_W-1){1'b0}}, 1'b1} : {OUT_W{1'b1}};
`else
    x      = {{(OUT_W-1){1'b0}}, MSB};
`endif
    strobe = (cnt == CNT_LAST);
    c1     = i3 - d1;
    c2     = c1 - d2;
    c3     = c2 - d3;
  end

  // Integrator chain. Wrap-around is modular and the combs cancel it.
  // NOTE: sequential state uses non-blocking assignments, so each stage reads its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else begin
      i1 <= i1 + x;
      i2 <= i2 + i1;
      i3 <= i3 + i2;
    end
  end

  // Free-running decimation counter. The strobe cycle is cnt == R-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DECIM_LOG2'(1);
    end
  end

  // Comb delays and the output register advance only on the strobe edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= strobe;
      if (strobe) begin
        d1   <= i3;
        d2   <= c1;
        d3   <= c2;
        dout <= c3;
      end
    end
  end

endmodule
